// File: rtl/axil_slave_regfile.sv
// axil_slave_regfile: AXI-Lite register file responder; define AXIL_SLAVE_SLVERR_EN to return SLVERR on out-of-range index instead of wrapping
module axil_slave_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int XW = ADDR_WIDTH - 2;
`ifdef AXIL_SLAVE_SLVERR_EN
  localparam bit SLVERR = 1'b1;
`else
  localparam bit SLVERR = 1'b0;
`endif
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t r_state, r_next;
  logic en, aw_done, w_done;
  logic [XW-1:0] aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, w_ok, r_ok;
  logic unused_ok;
  assign awready = en & ~aw_done & ~bvalid;
  assign wready  = en & ~w_done & ~bvalid;
  assign arready = en & (r_state == R_IDLE);
  assign rvalid  = r_state == R_DATA;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign b_hs    = bvalid & bready;
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;
  assign commit  = aw_done & w_done & ~bvalid;
  assign ar_idx  = araddr[ADDR_WIDTH-1:2];
  assign w_ok    = ~(SLVERR & ((aw_idx >> IW) != '0));
  assign r_ok    = ~(SLVERR & ((ar_idx >> IW) != '0));
  assign unused_ok = ^{awaddr[1:0], araddr[1:0]};
  always_comb begin
    r_next = (r_state == R_IDLE) ? (ar_hs ? R_DATA : R_IDLE) : (r_hs ? R_IDLE : R_DATA);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      rdata   <= '0;
      rresp   <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      en <= 1'b1;
      if (aw_hs) begin
        aw_done <= 1'b1;
        aw_idx  <= awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_done <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= w_ok ? 2'b00 : 2'b10;
        for (int b = 0; b < DATA_WIDTH/8; b++)
          if (w_ok & w_strb[b]) regs[aw_idx[IW-1:0]][8*b +: 8] <= w_data[8*b +: 8];
      end
      if (b_hs) begin
        bvalid  <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (ar_hs) begin
        rdata <= r_ok ? regs[ar_idx[IW-1:0]] : '0;
        rresp <= r_ok ? 2'b00 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb_axil_slave_regfile: directed AXI-Lite transactions against hand-computed register contents
module tb_axil_slave_regfile;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int errors = 0, checks = 0;
  logic [1:0] resp;
  logic [31:0] data;

  axil_slave_regfile dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    int n;
    bit aw_go, w_go;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go = wvalid && wready;
      tick();
      if (aw_go) awvalid = 1'b0;
      if (w_go) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0; n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("wr_bvalid", {31'd0, bvalid}, 32'd1);
    r = bresp; bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0; n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    check("rd_rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata; r = rresp; rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    tick(); tick();
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    check("rel_awready_lo", {31'd0, awready}, 32'd0);
    tick();
    check("rel_ready", {29'd0, awready, wready, arready}, 32'd7);

    axi_write(8'h10, 32'hB4B4B4B4, 4'hF, resp);
    check("w10_bresp", {30'd0, resp}, 32'd0);
    axi_read(8'h10, data, resp);
    check("r10_data", data, 32'hB4B4B4B4);
    check("r10_rresp", {30'd0, resp}, 32'd0);
    axi_read(8'h13, data, resp);
    check("r13_alias", data, 32'hB4B4B4B4);

    awaddr = 8'h04; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("wfirst_wready", {31'd0, wready}, 32'd0);
    tick(); tick();
    check("wfirst_nob", {31'd0, bvalid}, 32'd0);
    awvalid = 1'b1;
    check("wfirst_awready", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
    check("wfirst_b_early", {31'd0, bvalid}, 32'd0);
    tick();
    check("wfirst_b", {31'd0, bvalid}, 32'd1);
    check("wfirst_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(8'h04, data, resp);
    check("r04_data", data, 32'h12345678);

    axi_write(8'h08, 32'hFFFFFFFF, 4'hF, resp);
    axi_write(8'h08, 32'h00000000, 4'h5, resp);
    axi_read(8'h08, data, resp);
    check("r08_strb5", data, 32'hFF00FF00);
    axi_write(8'h08, 32'h00000000, 4'h0, resp);
    check("w08_strb0_bresp", {30'd0, resp}, 32'd0);
    axi_read(8'h08, data, resp);
    check("r08_strb0", data, 32'hFF00FF00);

    awaddr = 8'h0C; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    wdata = 32'h11111111;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_bvalid", {31'd0, bvalid}, 32'd1);
      check("hold_bresp", {30'd0, bresp}, 32'd0);
      check("hold_ready", {30'd0, awready, wready}, 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("hold_after_b", {30'd0, awready, wready}, 32'd3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("hold_second_b", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(8'h0C, data, resp);
    check("r0c_second", data, 32'h11111111);

    axi_write(8'hF3, 32'hB4B4B4B4, 4'hF, resp);
`ifdef AXIL_SLAVE_SLVERR_EN
    check("wf3_bresp", {30'd0, resp}, 32'd2);
    axi_read(8'hF3, data, resp);
    check("rf3_rresp", {30'd0, resp}, 32'd2);
    check("rf3_data", data, 32'd0);
    axi_read(8'h70, data, resp);
    check("r70_untouched", data, 32'd0);
`else
    check("wf3_bresp", {30'd0, resp}, 32'd0);
    axi_read(8'hF3, data, resp);
    check("rf3_rresp", {30'd0, resp}, 32'd0);
    check("rf3_data", data, 32'hB4B4B4B4);
    axi_read(8'h70, data, resp);
    check("r70_wrapped", data, 32'hB4B4B4B4);
`endif

    awaddr = 8'h14; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; araddr = 8'h14; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("rw_bvalid", {31'd0, bvalid}, 32'd1);
    check("rw_rvalid", {31'd0, rvalid}, 32'd1);
    check("rw_old_data", rdata, 32'd0);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(8'h14, data, resp);
    check("r14_new", data, 32'hCAFEF00D);

    araddr = 8'h10; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("stall_rvalid", {31'd0, rvalid}, 32'd1);
    tick(); tick();
    check("stall_rdata", rdata, 32'hB4B4B4B4);
    check("stall_rvalid2", {31'd0, rvalid}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_rst_arready", {31'd0, arready}, 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rel_arready", {31'd0, arready}, 32'd1);
    axi_read(8'h10, data, resp);
    check("r10_cleared", data, 32'd0);
    axi_read(8'h08, data, resp);
    check("r08_cleared", data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
